ahb_sram_slave: RTL
===================

// Module: ahb_sram_slave
// PURPOSE
//  AHB-Lite memory slave with programmable wait states. One instance feeds one
//  slave-return lane (hrdata_N/hreadyout_N/hresp_N) of the read-data mux.
//  Registers the address phase, holds the data phase for WAIT_STATES cycles,
//  then completes it. Responds with the two-cycle AHB ERROR on bad accesses.
// PARAMETERS
//  ADDR_WIDTH   10  byte-address bits decoded; memory = 2**(ADDR_WIDTH-2) words
//  WAIT_STATES  1   hreadyout-low cycles per OKAY data phase (0..15)
// PORTS
//  hclk       in   1   bus clock; all state changes on rising edge
//  hresetn    in   1   asynchronous active-low reset
//  hsel       in   1   slave select from decoder (address phase)
//  haddr      in   32  byte address (address phase)
//  hwrite     in   1   1=write, 0=read
//  htrans     in   2   00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  hsize      in   3   000 byte, 001 half, 010 word; others illegal
//  hwdata     in   32  write data (data phase)
//  hready     in   1   bus-wide ready (muxed hreadyout)
//  hrdata     out  32  read data, valid when hreadyout=1 in a read data phase
//  hreadyout  out  1   0 = stretch current data phase
//  hresp      out  1   0 OKAY, 1 ERROR
// BEHAVIOUR
//  Reset (async, hresetn=0): state IDLE, hreadyout=1, hresp=0, hrdata=0,
//   captured-phase regs cleared. Memory array not reset. Reset mid-transfer
//   aborts it; pending write is not committed.
//  Accept: address phase accepted when hsel & hready & htrans[1] at a rising
//   edge. haddr, hwrite and hsize are registered. hsel with IDLE/BUSY, or
//   hsel=0, gives zero-wait OKAY (hreadyout=1, hresp=0).
//  Error check at accept: hsize>2; half with haddr[0]=1; word with
//   haddr[1:0]!=0; haddr[31:ADDR_WIDTH]!=0. Any hit -> ERR1.
//  FSM states: IDLE, WAIT, ERR1, ERR2.
//   IDLE: accept OK -> WAIT (cnt=WAIT_STATES), or completes directly if
//     WAIT_STATES=0; accept bad -> ERR1.
//   WAIT: hreadyout=0 while cnt!=0, cnt decrements every cycle. When cnt==0,
//     hreadyout=1 and hresp=0 (completion cycle). If a new accept occurs in
//     the completion cycle, apply the IDLE rules to it, else go to IDLE.
//   ERR1: hreadyout=0, hresp=1, one cycle -> ERR2.
//   ERR2: hreadyout=1, hresp=1, one cycle. A new accept here follows the IDLE
//     rules. No memory access for errored transfers.
//  Latency: OKAY data phase = WAIT_STATES+1 cycles. WAIT_STATES=0 gives
//   back-to-back single-cycle pipelined transfers.
//  Write: hwdata is sampled at the end of the completion cycle. Little-endian
//   byte lanes: byte lane=addr[1:0]; half lanes {addr[1],0}+1..0; word all.
//   Unwritten lanes keep their value.
//  Read: hrdata = full memory word at the captured address, driven only in the
//   completion cycle, 0 otherwise. A read whose data phase immediately follows
//   a write to the same word returns the new data (write commits first).
//  hreadyout/hresp change only on the clock edge or reset. No combinational
//   path from inputs to them.
// TESTING
//  1 Reset: hresetn=0 mid-WAIT -> hreadyout=1, hresp=0, hrdata=0 at once;
//    target word unchanged.
//  2 WAIT_STATES=2: word write 0x0000_0010 <= 0xDEADBEEF, then read -> each
//    data phase has 2 cycles hreadyout=0, then hrdata=0xDEADBEEF, hresp=0.
//  3 WAIT_STATES=0, pipelined NONSEQ W@0x4 then SEQ R@0x4 -> both complete in
//    1 cycle each; read returns the just-written data.
//  4 Byte write 0xAA @0x21 over word 0x11223344 @0x20 -> read 0x1122AA44; then
//    half write 0xBBCC @0x22 -> read 0xBBCCAA44.
//  5 Word read @0x2 (unaligned) and word read @0x400 (out of range) -> each
//    gives hreadyout=0/hresp=1 then hreadyout=1/hresp=1; memory untouched.
//  6 hsel=1, htrans=IDLE, then BUSY -> hreadyout=1, hresp=0, no state change;
//    NONSEQ accepted in ERR2 cycle -> normal OKAY sequence follows.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with a programmable number of wait states.
// Drives one slave-return lane: hrdata / hreadyout / hresp.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no data phase in progress; hreadyout=1, hresp=OKAY
// WAIT  | OKAY data phase; stretched while r_cnt!=0, completes at r_cnt==0
// ERR1  | first ERROR cycle; hreadyout=0, hresp=1
// ERR2  | second ERROR cycle; hreadyout=1, hresp=1
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);

    localparam int         WORDS  = 2 ** (ADDR_WIDTH - 2);
    localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    state_t                  r_state;
    logic [3:0]              r_cnt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_write;
    logic [2:0]              r_size;
    logic                    r_hreadyout;
    logic                    r_hresp;
    logic [31:0]             r_mem [WORDS];

    logic                    w_accept;
    logic                    w_bad;
    logic                    w_complete;
    logic                    w_wr_en;
    logic [3:0]              w_be;
    logic [ADDR_WIDTH-3:0]   w_idx;
    logic                    w_unused_htrans0;

    // htrans[0] only separates NONSEQ from SEQ, which this slave treats alike.
    assign w_unused_htrans0 = htrans[0];

    // A new address phase is only taken in cycles where this slave is itself
    // ready (IDLE, WAIT completion, ERR2), so a stretched phase is never lost.
    assign w_accept   = hsel & hready & htrans[1] & r_hreadyout;
    assign w_complete = (r_state == ST_WAIT) && (r_cnt == 4'd0);
    assign w_wr_en    = w_complete & r_write;
    assign w_idx      = r_addr[ADDR_WIDTH-1:2];

    // Reject illegal sizes, misaligned halfwords/words and out-of-range addresses.
    always_comb begin
        w_bad = 1'b0;
        if (hsize > 3'd2)                              w_bad = 1'b1;
        if ((hsize == 3'd1) && haddr[0])               w_bad = 1'b1;
        if ((hsize == 3'd2) && (haddr[1:0] != 2'b00))  w_bad = 1'b1;
        if (haddr[31:ADDR_WIDTH] != '0)                w_bad = 1'b1;
    end

    // Little-endian byte enables from the captured size and address.
    always_comb begin
        w_be = 4'b0000;
        case (r_size)
            3'd0:    w_be[r_addr[1:0]] = 1'b1;
            3'd1:    w_be = r_addr[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    // Sequencer: address-phase capture, wait-state countdown and ERROR response.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_size      <= 3'd0;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
        end else begin
            if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    r_hreadyout <= 1'b1;
                end
            end else if (r_state == ST_ERR1) begin
                r_state     <= ST_ERR2;
                r_hreadyout <= 1'b1;
                r_hresp     <= 1'b1;
            end else if (w_accept && w_bad) begin
                r_state     <= ST_ERR1;
                r_hreadyout <= 1'b0;
                r_hresp     <= 1'b1;
            end else if (w_accept) begin
                r_state     <= ST_WAIT;
                r_cnt       <= WS_CNT;
                r_hreadyout <= (WAIT_STATES == 0);
                r_hresp     <= 1'b0;
                r_addr      <= haddr[ADDR_WIDTH-1:0];
                r_write     <= hwrite;
                r_size      <= hsize;
            end else begin
                r_state     <= ST_IDLE;
                r_hreadyout <= 1'b1;
                r_hresp     <= 1'b0;
            end
        end
    end

    // Write commits at the end of the completion cycle; the array is not reset.
    always_ff @(posedge hclk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

    // Read data is a direct array read, so a write committed on the previous
    // edge is already visible to a back-to-back read of the same word.
    assign hrdata    = (w_complete && !r_write) ? r_mem[w_idx] : 32'h0;
    assign hreadyout = r_hreadyout;
    assign hresp     = r_hresp;

endmodule
